// File: rtl/ss_game_sequencer.sv
// ---------------------------------------------------------------------------
// ss_game_sequencer
//   Game-round sequencer for a 4-digit seven-segment display driver.
//   IDLE waits for start. RUN counts down a 2-digit BCD value, one step per
//   SEC_DIV clocks. CONVERT turns the clamped 7-bit score into two BCD digits
//   by repeated subtraction of 10. OVER raises game_over and produces
//   blink_clk so the display driver can blink the final score.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse: begin/restart a round (IDLE/OVER)
//   player_dead           one-cycle pulse: end the round early (RUN)
//   score[6:0]            score, sampled in the first CONVERT cycle
//   count_s1/count_s0     countdown tens/ones digit (BCD)
//   score_tens/score_ones final score digits (BCD)
//   score_valid           score digits hold a finished conversion
//   game_over             high in OVER
//   blink_clk             blink phase, 0 outside OVER
//   time_up               one-cycle pulse when the countdown reaches 00
//   running               high in RUN
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module ss_game_sequencer #(
  parameter int unsigned SEC_DIV   = 100_000_000,
  parameter int unsigned BLINK_DIV = 25_000_000,
  parameter int unsigned START_SEC = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       player_dead,
  input  logic [6:0] score,
  output logic [3:0] count_s1,
  output logic [3:0] count_s0,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic       score_valid,
  output logic       game_over,
  output logic       blink_clk,
  output logic       time_up,
  output logic       running
);

  localparam int unsigned SEC_W   = (SEC_DIV   > 1) ? $clog2(SEC_DIV)   : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(SEC_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [3:0]         START_S1   = 4'(START_SEC / 10);
  localparam logic [3:0]         START_S0   = 4'(START_SEC % 10);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CONVERT, S_OVER} state_e;

  state_e               state_q, state_d;
  logic [SEC_W-1:0]     sec_cnt_q, sec_cnt_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic [3:0]           cnt_s1_q, cnt_s1_d, cnt_s0_q, cnt_s0_d;
  logic [6:0]           rem_q, rem_d;
  logic                 load_q, load_d;   // first CONVERT cycle: latch score
  logic [3:0]           tens_q, tens_d, ones_q, ones_d;
  logic                 valid_q, valid_d;
  logic                 game_over_q, game_over_d;
  logic                 blink_q, blink_d;
  logic                 time_up_q, time_up_d;
  logic                 running_q, running_d;

  logic sec_tick, final_tick, conv_done, enter_run;

  // The second tick is the cycle in which the divider wraps.
  assign sec_tick   = (state_q == S_RUN) && (sec_cnt_q == SEC_LAST);
  // A tick while showing 01 produces 00 and ends the round, even if
  // player_dead arrives in the same cycle.
  assign final_tick = sec_tick && (cnt_s1_q == 4'd0) && (cnt_s0_q == 4'd1);
  assign conv_done  = (state_q == S_CONVERT) && !load_q && (rem_q < 7'd10);
  assign enter_run  = (state_d == S_RUN) && (state_q != S_RUN);

  // State register and all datapath registers.
  // NOTE: every register here, including the small working ones, is reset so
  // that an asynchronous reset in any state leaves no stale pulses or digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sec_cnt_q   <= '0;
      blink_cnt_q <= '0;
      cnt_s1_q    <= START_S1;
      cnt_s0_q    <= START_S0;
      rem_q       <= '0;
      load_q      <= 1'b0;
      tens_q      <= '0;
      ones_q      <= '0;
      valid_q     <= 1'b0;
      game_over_q <= 1'b0;
      blink_q     <= 1'b0;
      time_up_q   <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      sec_cnt_q   <= sec_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      cnt_s1_q    <= cnt_s1_d;
      cnt_s0_q    <= cnt_s0_d;
      rem_q       <= rem_d;
      load_q      <= load_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      valid_q     <= valid_d;
      game_over_q <= game_over_d;
      blink_q     <= blink_d;
      time_up_q   <= time_up_d;
      running_q   <= running_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_RUN;
      S_RUN:     if (final_tick || player_dead) state_d = S_CONVERT;
      S_CONVERT: if (conv_done) state_d = S_OVER;
      S_OVER:    if (start) state_d = S_RUN;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    sec_cnt_d   = '0;
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    cnt_s1_d    = cnt_s1_q;
    cnt_s0_d    = cnt_s0_q;
    rem_d       = rem_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    valid_d     = valid_q;
    load_d      = (state_d == S_CONVERT) && (state_q != S_CONVERT);
    time_up_d   = final_tick;
    running_d   = (state_d == S_RUN);
    game_over_d = (state_d == S_OVER);

    // Second divider only runs while staying in RUN; any entry starts at 0.
    if (state_q == S_RUN && state_d == S_RUN)
      sec_cnt_d = sec_tick ? '0 : sec_cnt_q + 1'b1;

    // BCD decrement; the round leaves RUN at 00 so it never wraps.
    if (sec_tick) begin
      if (cnt_s0_q != 4'd0) begin
        cnt_s0_d = cnt_s0_q - 4'd1;
      end else begin
        cnt_s0_d = 4'd9;
        cnt_s1_d = cnt_s1_q - 4'd1;
      end
    end

    if (enter_run) begin
      cnt_s1_d = START_S1;
      cnt_s0_d = START_S0;
      valid_d  = 1'b0;
    end

    // Score to BCD: latch clamped score, then subtract 10 per cycle.
    if (state_q == S_CONVERT) begin
      if (load_q) begin
        rem_d   = (score > 7'd99) ? 7'd99 : score;
        tens_d  = '0;
        valid_d = 1'b0;
      end else if (rem_q >= 7'd10) begin
        rem_d  = rem_q - 7'd10;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d  = rem_q[3:0];
        valid_d = 1'b1;
      end
    end

    // Blink divider runs only while staying in OVER; entry starts at phase 0.
    if (state_q == S_OVER && state_d == S_OVER) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_d     = blink_q;
      end
    end
  end

  assign count_s1    = cnt_s1_q;
  assign count_s0    = cnt_s0_q;
  assign score_tens  = tens_q;
  assign score_ones  = ones_q;
  assign score_valid = valid_q;
  assign game_over   = game_over_q;
  assign blink_clk   = blink_q;
  assign time_up     = time_up_q;
  assign running     = running_q;

endmodule

// File: tb/tb_ss_game_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ss_game_sequencer
//   Self-checking bench for ss_game_sequencer with SEC_DIV=4, BLINK_DIV=3,
//   START_SEC=12. Round vectors live in a table of {inputs, expected}
//   records; each round pushes its record to a scoreboard queue when it is
//   started and pops it when the DUT reaches OVER. Hand-written sequences
//   cover the step-by-step countdown, blink timing, the coincident
//   death/final-tick case and asynchronous reset mid-round.
// ---------------------------------------------------------------------------
module tb_ss_game_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       player_dead = 1'b0;
  logic [6:0] score = '0;
  logic [3:0] count_s1, count_s0, score_tens, score_ones;
  logic       score_valid, game_over, blink_clk, time_up, running;

  ss_game_sequencer #(.SEC_DIV(4), .BLINK_DIV(3), .START_SEC(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .player_dead (player_dead),
    .score       (score),
    .count_s1    (count_s1),
    .count_s0    (count_s0),
    .score_tens  (score_tens),
    .score_ones  (score_ones),
    .score_valid (score_valid),
    .game_over   (game_over),
    .blink_clk   (blink_clk),
    .time_up     (time_up),
    .running     (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int score;     // score input for the round
    int die_at;    // count value at which player_dead pulses, -1 = never
    int exp_tens;
    int exp_ones;
    int exp_s1;    // frozen countdown digits in OVER
    int exp_s0;
    int exp_lat;   // CONVERT entry to OVER entry in cycles, -1 = only <= 11
  } vec_t;

  vec_t vecs[6];
  vec_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int tu_count = 0;

  always @(negedge clk) if (time_up) tu_count++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic int cur_count();
    return int'(count_s1) * 10 + int'(count_s0);
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_s1"},    int'(count_s1), 1);
    check({tag, "_s0"},    int'(count_s0), 2);
    check({tag, "_tens"},  int'(score_tens), 0);
    check({tag, "_ones"},  int'(score_ones), 0);
    check({tag, "_valid"}, int'(score_valid), 0);
    check({tag, "_over"},  int'(game_over), 0);
    check({tag, "_blink"}, int'(blink_clk), 0);
    check({tag, "_tu"},    int'(time_up), 0);
    check({tag, "_run"},   int'(running), 0);
  endtask

  // Ticks until game_over, at most `budget` cycles; returns cycles taken.
  task automatic wait_over(input int budget, output int cyc);
    cyc = 0;
    while (!game_over && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_round(input vec_t v, input int idx);
    int   conv_at, over_at;
    bit   died;
    vec_t e;
    string t;
    t = $sformatf("vec%0d", idx);
    score = 7'(v.score);
    sb_q.push_back(v);
    tu_count = 0;
    pulse_start();
    check({t, "_start_run"},   int'(running), 1);
    check({t, "_start_cnt"},   cur_count(), 12);
    check({t, "_start_over"},  int'(game_over), 0);
    check({t, "_start_valid"}, int'(score_valid), 0);
    check({t, "_start_blink"}, int'(blink_clk), 0);
    died = 1'b0;
    conv_at = -1;
    over_at = -1;
    for (int cyc = 1; cyc <= 200 && over_at < 0; cyc++) begin
      if (running && !died && v.die_at >= 0 && cur_count() == v.die_at) begin
        player_dead = 1'b1;
        died = 1'b1;
      end
      tick();
      player_dead = 1'b0;
      if (conv_at < 0 && !running) conv_at = cyc;
      if (game_over) over_at = cyc;
    end
    e = sb_q.pop_front();
    if (over_at < 0 || conv_at < 0) begin
      check({t, "_timeout"}, 0, 1);
    end else begin
      check({t, "_tens"},  int'(score_tens), e.exp_tens);
      check({t, "_ones"},  int'(score_ones), e.exp_ones);
      check({t, "_valid"}, int'(score_valid), 1);
      check({t, "_s1"},    int'(count_s1), e.exp_s1);
      check({t, "_s0"},    int'(count_s0), e.exp_s0);
      check({t, "_blink0"}, int'(blink_clk), 0);
      check({t, "_tu_cnt"}, tu_count, (e.die_at < 0) ? 1 : 0);
      if (e.exp_lat >= 0) check({t, "_lat"}, over_at - conv_at, e.exp_lat);
      else                check({t, "_lat_le11"}, int'((over_at - conv_at) <= 11), 1);
    end
  endtask

  initial begin
    int  lat;
    bit  ok;

    vecs[0] = '{57,  7, 5, 7, 0, 7, -1};
    vecs[1] = '{120, 11, 9, 9, 1, 1, 11};
    vecs[2] = '{0,   5, 0, 0, 0, 5, 2};
    vecs[3] = '{99, -1, 9, 9, 0, 0, 11};
    vecs[4] = '{10, 12, 1, 0, 1, 2, -1};
    vecs[5] = '{100, 3, 9, 9, 0, 3, 11};

    // Reset state.
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    repeat (5) tick();
    check("idle_hold_cnt", cur_count(), 12);
    check("idle_run", int'(running), 0);

    // Full countdown with no death, including the 10 -> 09 borrow.
    score = 7'd42;
    tu_count = 0;
    pulse_start();
    check("cd_running", int'(running), 1);
    for (int v = 11; v >= 0; v--) begin
      repeat (3) tick();
      check($sformatf("cd_hold_%0d", v + 1), cur_count(), v + 1);
      tick();
      check($sformatf("cd_s1_%0d", v), int'(count_s1), v / 10);
      check($sformatf("cd_s0_%0d", v), int'(count_s0), v % 10);
      check($sformatf("cd_tu_%0d", v), int'(time_up), (v == 0) ? 1 : 0);
    end
    check("cd_left_run", int'(running), 0);
    wait_over(20, lat);
    check("cd_over", int'(game_over), 1);
    check("cd_lat_le11", int'(lat <= 11), 1);
    check("cd_tens", int'(score_tens), 4);
    check("cd_ones", int'(score_ones), 2);
    check("cd_cnt_00", cur_count(), 0);
    check("cd_tu_once", tu_count, 1);

    // Blink: 0 on entry, toggles every 3 cycles.
    check("bl_entry", int'(blink_clk), 0);
    repeat (2) tick();
    check("bl_c2", int'(blink_clk), 0);
    tick();
    check("bl_c3", int'(blink_clk), 1);
    repeat (2) tick();
    check("bl_c5", int'(blink_clk), 1);
    tick();
    check("bl_c6", int'(blink_clk), 0);
    check("bl_hold_tens", int'(score_tens), 4);
    check("bl_hold_over", int'(game_over), 1);

    // Table-driven rounds, each restarted from OVER.
    for (int i = 0; i < 6; i++) run_round(vecs[i], i);

    // player_dead on the same cycle as the final tick.
    score = 7'd35;
    pulse_start();
    tu_count = 0;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      tick();
      if (cur_count() == 1) ok = 1'b1;
    end
    check("co_reach_01", int'(ok), 1);
    repeat (3) tick();
    player_dead = 1'b1;
    tick();
    player_dead = 1'b0;
    check("co_cnt_00", cur_count(), 0);
    check("co_tu", int'(time_up), 1);
    check("co_run", int'(running), 0);
    wait_over(20, lat);
    check("co_over", int'(game_over), 1);
    check("co_lat_le11", int'(lat <= 11), 1);
    check("co_tens", int'(score_tens), 3);
    check("co_ones", int'(score_ones), 5);
    repeat (3) tick();
    check("co_tu_once", tu_count, 1);
    check("co_still_over", int'(game_over), 1);
    check("co_still_valid", int'(score_valid), 1);

    // Reset in the middle of CONVERT.
    score = 7'd99;
    pulse_start();
    for (int c = 0; c < 100 && running; c++) tick();
    repeat (3) tick();
    check("rc_pre_tens", int'(score_tens), 2);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rc");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rc_idle_cnt", cur_count(), 12);

    // Reset in the middle of OVER.
    score = 7'd57;
    pulse_start();
    for (int c = 0; c < 100 && running; c++) tick();
    wait_over(20, lat);
    repeat (4) tick();
    check("ro_pre_blink", int'(blink_clk), 1);
    check("ro_pre_valid", int'(score_valid), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("ro");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pulse_start();
    check("ro_restart_run", int'(running), 1);
    repeat (4) tick();
    check("ro_restart_11", cur_count(), 11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
